bin2bcd_display_source: RTL

//  Upstream feeder for the 4-digit 7-segment display driver: converts an unsigned binary count into

---
 rtl/display_pkg.sv | 30 +++
 rtl/bin2bcd_display_source_if.sv | 30 +++
 rtl/bcd_digit_adjust.sv | 20 ++
 rtl/bin2bcd_display_source.sv | 116 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types, constants and helpers for the BCD display source.
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    // Conversion FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Bits per BCD digit
    localparam int BCD_NIBBLE = 4;

    // Largest decimal value representable with the given number of digits
    function automatic logic [63:0] max_decimal(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_display_source_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_display_source_if
//  Purpose  : start/busy/done conversion handshake and BCD result bus.
//  Revision : 1.0  initial release
// ============================================================================
interface bin2bcd_display_source_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                   start;
    logic [BIN_WIDTH-1:0]   binval;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [4*DIGITS-1:0]    bcdval;

    // Requester side: issues conversions, observes the result
    modport master (
        output start, binval,
        input  busy, done, overflow, bcdval
    );

    // Converter side
    modport slave (
        input  start, binval,
        output busy, done, overflow, bcdval
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adjust
//  Purpose  : Double-dabble digit correction: adds 3 when the digit is >= 5,
//             so the following left shift carries correctly in decimal.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adjust (
    input  wire logic [3:0] i_digit,
    output logic      [3:0] o_digit
);
    // Pre-shift correction of one BCD digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bin2bcd_display_source.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_display_source
//  Purpose  : Iterative binary-to-packed-BCD converter (one bit per clock)
//             feeding a 7-segment display; the result is only updated when a
//             conversion completes.
//  Options  : BIN2BCD_SATURATE_EN - show all nines when the value overflows.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_display_source
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    bin2bcd_display_source_if.slave   bus
);
    localparam int                   c_BCD_W     = BCD_NIBBLE * DIGITS;
    localparam int                   c_CNT_W     = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST_BIT  = c_CNT_W'(BIN_WIDTH - 1);
    localparam logic [63:0]          c_MAX_DEC   = max_decimal(DIGITS);
    // BCD image of max_decimal(DIGITS)
    localparam logic [c_BCD_W-1:0]   c_ALL_NINES = {DIGITS{4'h9}};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [BIN_WIDTH-1:0]   r_bin;
    logic [c_BCD_W-1:0]     r_scratch;
    logic [c_BCD_W-1:0]     w_adj;
    logic [c_BCD_W-1:0]     w_shifted;
    logic [c_BCD_W-1:0]     r_bcdval;
    logic                   r_ovf_next;
    logic                   r_overflow;
    logic                   w_ovf_in;
    logic                   w_accept;
    logic                   w_last;

    // One add-3 corrector per scratch digit
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_scratch[gi*BCD_NIBBLE +: BCD_NIBBLE]),
            .o_digit (w_adj[gi*BCD_NIBBLE +: BCD_NIBBLE])
        );
    end

    assign w_accept  = (r_state == ST_IDLE) && bus.start;
    assign w_last    = (r_state == ST_SHIFT) && (r_bit_cnt == c_LAST_BIT);
    // Bits leaving the top digit are dropped: raw result is binval mod 10^DIGITS
    assign w_shifted = {w_adj[c_BCD_W-2:0], r_bin[BIN_WIDTH-1]};
    assign w_ovf_in  = (64'(bus.binval) > c_MAX_DEC);

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_next = ST_LOAD;
            ST_LOAD:                 w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, shift-add-3, and result registers loaded on the
    // final shift so they are already valid while done is high in LOAD
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bit_cnt  <= '0;
            r_bin      <= '0;
            r_scratch  <= '0;
            r_ovf_next <= 1'b0;
            r_overflow <= 1'b0;
            r_bcdval   <= '0;
        end else begin
            if (w_accept) begin
                r_bin      <= bus.binval;
                r_scratch  <= '0;
                r_bit_cnt  <= '0;
                r_ovf_next <= w_ovf_in;
            end else if (r_state == ST_SHIFT) begin
                r_scratch  <= w_shifted;
                r_bin      <= r_bin << 1;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
            if (w_last) begin
                r_overflow <= r_ovf_next;
`ifdef BIN2BCD_SATURATE_EN
                r_bcdval   <= r_ovf_next ? c_ALL_NINES : w_shifted;
`else
                r_bcdval   <= w_shifted;
`endif
            end
        end
    end

    // Output decode
    always_comb begin
        bus.busy     = (r_state == ST_SHIFT);
        bus.done     = (r_state == ST_LOAD);
        bus.overflow = r_overflow;
        bus.bcdval   = r_bcdval;
    end

endmodule
`default_nettype wire
